// File: rtl/grf_sb.sv
// General-register file with a per-register pending-write scoreboard.
// Decode reads and reserves destinations; write-back retires them; flush drops all reservations.
module grf_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned PEND_W   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ok,
  input  logic                     flush,
  output logic                     wr_orphan
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [PEND_W-1:0] pend_q [DEPTH];
  logic [PEND_W-1:0] pend_d [DEPTH];
  logic              orphan_q, orphan_d;

  logic wr_zero, rsv_zero, wr_valid, rsv_inc;

  assign wr_zero  = ZERO_REG && (waddr == '0);
  assign rsv_zero = ZERO_REG && (rsv_addr == '0);
  assign wr_valid = we && !wr_zero;

  // Reservation accepted unless saturated; a same-address retire frees a slot this cycle.
  always_comb begin
    rsv_ok = 1'b0;
    if (rsv_en) begin
      if (rsv_zero) begin
        rsv_ok = 1'b1;
      end else begin
        rsv_ok = (pend_q[rsv_addr] != PEND_MAX) || (we && (waddr == rsv_addr));
      end
    end
  end

  assign rsv_inc = rsv_ok && !rsv_zero;

  // Next-state for data, pending counters and the orphan flag.
  always_comb begin
    regs_d   = regs_q;
    pend_d   = pend_q;
    orphan_d = 1'b0;
    if (wr_valid) begin
      regs_d[waddr] = wdata;
      orphan_d      = (pend_q[waddr] == '0);
    end
    if (!(rsv_inc && wr_valid && (rsv_addr == waddr))) begin
      if (rsv_inc) begin
        pend_d[rsv_addr] = pend_q[rsv_addr] + PEND_ONE;
      end
      if (wr_valid && (pend_q[waddr] != '0)) begin
        pend_d[waddr] = pend_q[waddr] - PEND_ONE;
      end
    end
    if (flush) begin
      for (int a = 0; a < DEPTH; a++) begin
        pend_d[a] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int a = 0; a < DEPTH; a++) begin
        regs_q[a] <= '0;
        pend_q[a] <= '0;
      end
      orphan_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      pend_q   <= pend_d;
      orphan_q <= orphan_d;
    end
  end

  assign wr_orphan = orphan_q;

  // Read ports: register-0 override, then optional write bypass, then storage.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              zero_hit, byp_hit, last_wr;
    logic [DATA_W-1:0] rd;
    logic              busy;

    assign ra       = raddr[i*ADDR_W +: ADDR_W];
    assign zero_hit = ZERO_REG && (ra == '0);
    assign byp_hit  = BYPASS && reset && we && (waddr == ra);
    assign last_wr  = byp_hit && (pend_q[ra] == PEND_ONE);

    assign rd   = zero_hit ? '0 : (byp_hit ? wdata : regs_q[ra]);
    assign busy = !zero_hit && !last_wr && (pend_q[ra] != '0);

    assign rdata[i*DATA_W +: DATA_W] = rd;
    assign rbusy[i]                  = busy;
  end

endmodule

// File: tb/tb_grf_sb.sv
// Scoreboard bench for grf_sb: a bypassing and a non-bypassing instance share all inputs.
module tb_grf_sb;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;
  localparam int unsigned PW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata, rdata_nb;
  logic [NR-1:0]    rbusy, rbusy_nb;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic             rsv_ok, rsv_ok_nb;
  logic             flush;
  logic             wr_orphan, wr_orphan_nb;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [63:0] exp;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  grf_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PEND_W(PW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .we(we), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(rsv_ok), .flush(flush), .wr_orphan(wr_orphan)
  );

  grf_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .PEND_W(PW), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
    .we(we), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(rsv_ok_nb), .flush(flush), .wr_orphan(wr_orphan_nb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0;
    rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int p1, input int p0);
    raddr = {AW'(p1), AW'(p0)};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd5;
    set_rd(3, 5);
    sb.push_back('{"rst_rdata", 64'h0});
    sb.push_back('{"rst_rbusy", 64'h0});
    sb.push_back('{"rst_rsv_ok", 64'h1});
    sb.push_back('{"rst_orphan", 64'h0});
    #2;
    e = sb.pop_front(); total++;
    if (64'(rdata) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rdata, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(rbusy) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(rsv_ok) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rsv_ok, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(wr_orphan) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, wr_orphan, e.exp); end
    tick();
    reset = 1'b1;
    rsv_en = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd7; wdata = 32'hAAAA_0001;
    tick();
    wdata = 32'h1234_5678;
    set_rd(7, 0);
    sb.push_back('{"byp_same_cycle", {32'h1234_5678, 32'h0}});
    sb.push_back('{"nobyp_old_value", {32'hAAAA_0001, 32'h0}});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rdata) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rdata, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(rdata_nb) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rdata_nb, e.exp); end
    tick();
    idle();
    sb.push_back('{"nobyp_after_write", {32'h1234_5678, 32'h0}});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rdata_nb) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rdata_nb, e.exp); end
  endtask

  task automatic test_scoreboard();
    tick();
    rsv_en = 1'b1; rsv_addr = 5'd3;
    sb.push_back('{"sb_rsv_ok", 64'h1});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rsv_ok) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rsv_ok, e.exp); end
    tick();
    tick();
    idle();
    set_rd(7, 3);
    sb.push_back('{"sb_busy_reserved", 64'h1});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rbusy) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy, e.exp); end
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0301;
    sb.push_back('{"sb_busy_first_wr", 64'h1});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rbusy) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy, e.exp); end
    tick();
    wdata = 32'h0000_0302;
    sb.push_back('{"sb_busy_last_wr_byp", 64'h0});
    sb.push_back('{"sb_busy_last_wr_nobyp", 64'h1});
    sb.push_back('{"sb_rdata_last_wr", {32'h1234_5678, 32'h0000_0302}});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rbusy) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(rbusy_nb) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy_nb, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(rdata) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rdata, e.exp); end
    tick();
    idle();
    sb.push_back('{"sb_busy_retired", 64'h0});
    sb.push_back('{"sb_no_orphan", 64'h0});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rbusy_nb) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy_nb, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(wr_orphan) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, wr_orphan, e.exp); end
  endtask

  task automatic test_saturation();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    set_rd(0, 9);
    tick();
    tick();
    tick();
    sb.push_back('{"sat_refused", 64'h0});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rsv_ok) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rsv_ok, e.exp); end
    tick();
    we = 1'b1; waddr = 5'd9; wdata = 32'h9999_0000;
    sb.push_back('{"sat_ok_with_write", 64'h1});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rsv_ok) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rsv_ok, e.exp); end
    tick();
    rsv_en = 1'b0;
    tick();
    tick();
    we = 1'b0;
    sb.push_back('{"sat_one_left", 64'h1});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rbusy) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy, e.exp); end
    we = 1'b1;
    tick();
    idle();
    sb.push_back('{"sat_drained", 64'h0});
    sb.push_back('{"sat_no_orphan", 64'h0});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rbusy) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(wr_orphan) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, wr_orphan, e.exp); end
  endtask

  task automatic test_orphan_zero();
    tick();
    set_rd(0, 4);
    we = 1'b1; waddr = 5'd4; wdata = 32'hCAFE_F00D;
    tick();
    idle();
    sb.push_back('{"orphan_pulse", 64'h1});
    sb.push_back('{"orphan_data", {32'h0, 32'hCAFE_F00D}});
    #1;
    e = sb.pop_front(); total++;
    if (64'(wr_orphan) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, wr_orphan, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(rdata_nb) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rdata_nb, e.exp); end
    tick();
    sb.push_back('{"orphan_one_cycle", 64'h0});
    #1;
    e = sb.pop_front(); total++;
    if (64'(wr_orphan) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, wr_orphan, e.exp); end
    set_rd(0, 0);
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    sb.push_back('{"zero_rdata", 64'h0});
    sb.push_back('{"zero_rbusy", 64'h0});
    sb.push_back('{"zero_rsv_ok", 64'h1});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rdata) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rdata, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(rbusy) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(rsv_ok) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rsv_ok, e.exp); end
    tick();
    idle();
    sb.push_back('{"zero_after_rdata", 64'h0});
    sb.push_back('{"zero_after_rbusy", 64'h0});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rdata_nb) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rdata_nb, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(rbusy_nb) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy_nb, e.exp); end
  endtask

  task automatic test_flush();
    for (int a = 1; a <= 3; a++) begin
      rsv_en = 1'b1; rsv_addr = AW'(a);
      tick();
    end
    idle();
    set_rd(2, 1);
    sb.push_back('{"flush_pre_busy", 64'h3});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rbusy) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy, e.exp); end
    flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd6;
    sb.push_back('{"flush_rsv_ok", 64'h1});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rsv_ok) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rsv_ok, e.exp); end
    tick();
    idle();
    sb.push_back('{"flush_busy_1_2", 64'h0});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rbusy) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy, e.exp); end
    set_rd(6, 3);
    sb.push_back('{"flush_busy_3_6", 64'h0});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rbusy) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy, e.exp); end
  endtask

  task automatic test_reset_mid();
    tick();
    we = 1'b1; waddr = 5'd10; wdata = 32'h5555_5555;
    rsv_en = 1'b1; rsv_addr = 5'd11;
    tick();
    idle();
    set_rd(11, 10);
    sb.push_back('{"mid_pre_rdata", {32'h0, 32'h5555_5555}});
    sb.push_back('{"mid_pre_rbusy", 64'h2});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rdata) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rdata, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(rbusy) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy, e.exp); end
    #1;
    reset = 1'b0;
    sb.push_back('{"mid_async_rdata", 64'h0});
    sb.push_back('{"mid_async_rbusy", 64'h0});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rdata) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rdata, e.exp); end
    e = sb.pop_front(); total++;
    if (64'(rbusy) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rbusy, e.exp); end
    tick();
    reset = 1'b1;
    set_rd(0, 5);
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    tick();
    idle();
    sb.push_back('{"mid_post_write", {32'h0, 32'hDEAD_BEEF}});
    #1;
    e = sb.pop_front(); total++;
    if (64'(rdata) !== e.exp) begin bad++; $display("FAIL %s got=%h exp=%h", e.name, rdata, e.exp); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_scoreboard();
    test_saturation();
    test_orphan_zero();
    test_flush();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
